led_bank_issuer: RTL and testbench



---
 rtl/led_bank_pkg.sv | 33 +++
 rtl/led_bank_lsb_pick.sv | 18 +
 rtl/led_bank_issuer.sv | 128 ++++++++++++
 tb/tb_led_bank_issuer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_bank_pkg.sv
// Shared definitions for the LedBank instruction interface: widths, opcodes,
// issuer FSM states and the LDn instruction builder.
package led_bank_pkg;

  localparam int INST_W = 12;
  localparam int OPC_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_LD0 = 4'h2;
  localparam logic [OPC_W-1:0] OP_LD1 = 4'h3;
  localparam logic [OPC_W-1:0] OP_LD2 = 4'h4;
  localparam logic [OPC_W-1:0] OP_LD3 = 4'h5;
  localparam logic [OPC_W-1:0] OP_LD4 = 4'h6;
  localparam logic [OPC_W-1:0] OP_LD5 = 4'h7;
  localparam logic [OPC_W-1:0] OP_LD6 = 4'h8;
  localparam logic [OPC_W-1:0] OP_LD7 = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOADI = 2'd1,
    ST_BITS  = 2'd2
  } state_t;

  // LDn opcodes are contiguous, so bit n maps to OP_LD0 + n.
  function automatic logic [INST_W-1:0] ldn_inst(input logic [2:0] n, input logic value);
    logic [OPC_W-1:0] opc;
    opc = OP_LD0 + {1'b0, n};
    return {opc, 7'b0, value};
  endfunction

endpackage

// File: rtl/led_bank_lsb_pick.sv
// Lowest-set-bit encoder for an 8-bit vector; idx is 0 when no bit is set.
module led_bank_lsb_pick (
  input  logic [7:0] bits,
  output logic [2:0] idx,
  output logic       any
);

  // Scanning from the top down lets the lowest set bit overwrite the others.
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) idx = 3'(i);
    end
  end

  assign any = |bits;

endmodule

// File: rtl/led_bank_issuer.sv
// LedBank initiator: tracks a shadow of the LED state and reaches each target
// pattern with either per-bit LDn instructions or a single LDI.
module led_bank_issuer
  import led_bank_pkg::*;
#(
  parameter int THRESH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pat,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic              resync,
  output logic [INST_W-1:0] inst,
  output logic              inst_en
);

  localparam logic [3:0] THRESH_C = 4'(THRESH);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tgt, tgt_nxt;
  logic [DATA_W-1:0] diff, diff_nxt;
  logic [DATA_W-1:0] shadow, shadow_nxt;
  logic              synced, synced_nxt;
  logic              rs_flag, rs_flag_nxt;
  logic [INST_W-1:0] inst_nxt;
  logic              inst_en_nxt;

  logic [DATA_W-1:0] pat_diff;
  logic [3:0]        pat_ones;
  logic              accept;
  logic              want_ldi;
  logic [2:0]        cur_idx, nxt_idx;
  logic              cur_any, nxt_any;

  assign pat_ready = (state == ST_IDLE) && !reset;
  assign accept    = pat_valid && pat_ready;
  assign pat_diff  = pat ^ shadow;

  always_comb begin
    pat_ones = '0;
    for (int i = 0; i < DATA_W; i++) pat_ones = pat_ones + {3'b0, pat_diff[i]};
  end

  // A resync pulse on the accept edge itself also forces LDI.
  assign want_ldi = !synced || rs_flag || resync || (pat_ones > THRESH_C);

  // cur_* selects the bit being issued now; nxt_* the bit to issue next cycle.
  led_bank_lsb_pick u_pick_cur (.bits(diff),     .idx(cur_idx), .any(cur_any));
  led_bank_lsb_pick u_pick_nxt (.bits(diff_nxt), .idx(nxt_idx), .any(nxt_any));

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    diff_nxt    = diff;
    shadow_nxt  = shadow;
    synced_nxt  = synced;
    rs_flag_nxt = rs_flag | resync;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          tgt_nxt  = pat;
          diff_nxt = pat_diff;
          if (want_ldi)            state_nxt = ST_LOADI;
          else if (|pat_diff)      state_nxt = ST_BITS;
        end
      end
      ST_LOADI: begin
        shadow_nxt  = tgt;
        synced_nxt  = 1'b1;
        rs_flag_nxt = resync;
        state_nxt   = ST_IDLE;
      end
      ST_BITS: begin
        if (cur_any) begin
          shadow_nxt[cur_idx] = tgt[cur_idx];
          diff_nxt[cur_idx]   = 1'b0;
        end
        if (!(|diff_nxt)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The instruction is registered, so it is derived from the state being entered.
  always_comb begin
    inst_en_nxt = 1'b0;
    inst_nxt    = '0;
    case (state_nxt)
      ST_LOADI: begin
        inst_en_nxt = 1'b1;
        inst_nxt    = {OP_LDI, tgt_nxt};
      end
      ST_BITS: begin
        if (nxt_any) begin
          inst_en_nxt = 1'b1;
          inst_nxt    = ldn_inst(nxt_idx, tgt_nxt[nxt_idx]);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tgt     <= '0;
      diff    <= '0;
      shadow  <= '0;
      synced  <= 1'b0;
      rs_flag <= 1'b0;
      inst    <= '0;
      inst_en <= 1'b0;
    end else begin
      state   <= state_nxt;
      tgt     <= tgt_nxt;
      diff    <= diff_nxt;
      shadow  <= shadow_nxt;
      synced  <= synced_nxt;
      rs_flag <= rs_flag_nxt;
      inst    <= inst_nxt;
      inst_en <= inst_en_nxt;
    end
  end

endmodule

// File: tb/tb_led_bank_issuer.sv
// Scoreboard bench: two issuers (THRESH=3 and THRESH=0) share stimulus; a
// pattern-level model queues expected instructions, a monitor pops and compares.
module tb_led_bank_issuer;

  logic        clock;
  logic        reset;
  logic [7:0]  pat;
  logic        pat_valid;
  logic        resync;
  logic [11:0] inst_w [2];
  logic        en_w   [2];
  logic        rdy_w  [2];

  int checks = 0;
  int errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [7:0]  m_shadow [2];
  bit          m_synced [2];
  bit          m_flag   [2];
  int          th       [2] = '{3, 0};

  led_bank_issuer #(.THRESH(3)) dut0 (
    .clock(clock), .reset(reset), .pat(pat), .pat_valid(pat_valid),
    .pat_ready(rdy_w[0]), .resync(resync), .inst(inst_w[0]), .inst_en(en_w[0])
  );

  led_bank_issuer #(.THRESH(0)) dut1 (
    .clock(clock), .reset(reset), .pat(pat), .pat_valid(pat_valid),
    .pat_ready(rdy_w[1]), .resync(resync), .inst(inst_w[1]), .inst_en(en_w[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [11:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_shadow[d] = 8'h00;
      m_synced[d] = 1'b0;
      m_flag[d]   = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Pattern-level rule: LDI when unsynced, after a resync, or too many bits
  // change; otherwise one LDn per changed bit in ascending bit order.
  task automatic model_accept(input int d, input logic [7:0] p, input logic rs, output int n);
    logic [7:0] dif;
    dif = p ^ m_shadow[d];
    n = 0;
    if (!m_synced[d] || m_flag[d] || rs || ($countones(dif) > th[d])) begin
      push(d, {4'h1, p});
      n = 1;
      m_synced[d] = 1'b1;
      m_flag[d]   = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (dif[i]) begin
          push(d, {4'(2 + i), 7'b0, p[i]});
          n++;
        end
      end
    end
    m_shadow[d] = p;
  endtask

  // Monitor: every negedge, each issuer either presents the next queued
  // instruction or drives an idle all-zero bus.
  initial begin
    logic [11:0] exp;
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int d = 0; d < 2; d++) begin
          if (en_w[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
              check($sformatf("dut%0d unexpected inst", d), {20'b0, inst_w[d]}, 32'hFFFFFFFF);
            end else begin
              exp = (d == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("dut%0d inst", d), {20'b0, inst_w[d]}, {20'b0, exp});
            end
          end else begin
            check($sformatf("dut%0d idle inst", d), {20'b0, inst_w[d]}, 32'h0);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!(rdy_w[0] && rdy_w[1]) && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 50) check("pat_ready timeout", 32'h0, 32'h1);
  endtask

  // Offer one pattern; both issuers accept on the same edge. Afterwards check
  // that pat_ready stays low for exactly as many cycles as instructions queued.
  task automatic send(input logic [7:0] p, input logic rs, input logic mid_rs);
    int n[2];
    int lat[2];
    wait_ready();
    pat       = p;
    pat_valid = 1'b1;
    resync    = rs;
    for (int d = 0; d < 2; d++) model_accept(d, p, rs, n[d]);
    @(posedge clock);
    #1;
    pat_valid = 1'b0;
    resync    = 1'b0;
    lat = '{-1, -1};
    for (int k = 0; k < 20 && (lat[0] < 0 || lat[1] < 0); k++) begin
      @(negedge clock);
      if (k == 1) resync = 1'b0;
      if (k == 0 && mid_rs) begin
        resync    = 1'b1;
        m_flag[0] = 1'b1;
        m_flag[1] = 1'b1;
      end
      for (int d = 0; d < 2; d++) if (lat[d] < 0 && rdy_w[d]) lat[d] = k;
    end
    if (resync) begin
      @(negedge clock);
      resync = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d busy cycles pat %02h", d, p), lat[d], n[d]);
  endtask

  // Reset lands while dut0 presents the second LDn of the pattern.
  task automatic send_abort(input logic [7:0] p);
    int n[2];
    logic [11:0] exp;
    wait_ready();
    pat       = p;
    pat_valid = 1'b1;
    for (int d = 0; d < 2; d++) model_accept(d, p, 1'b0, n[d]);
    @(posedge clock);
    #1;
    pat_valid = 1'b0;
    @(posedge clock);
    #1;
    exp = (q0.size() > 0) ? q0.pop_front() : 12'hFFF;
    check("dut0 second LDn before reset", {20'b0, inst_w[0]}, {20'b0, exp});
    #1;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d inst_en on async reset", d), {31'b0, en_w[d]}, 32'h0);
      check($sformatf("dut%0d inst on async reset", d), {20'b0, inst_w[d]}, 32'h0);
      check($sformatf("dut%0d pat_ready in reset", d), {31'b0, rdy_w[d]}, 32'h0);
    end
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] m;
    pat       = 8'h00;
    pat_valid = 1'b0;
    resync    = 1'b0;
    reset     = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset inst", d), {20'b0, inst_w[d]}, 32'h0);
      check($sformatf("dut%0d reset inst_en", d), {31'b0, en_w[d]}, 32'h0);
      check($sformatf("dut%0d reset pat_ready", d), {31'b0, rdy_w[d]}, 32'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d pat_ready after reset", d), {31'b0, rdy_w[d]}, 32'h1);

    send(8'h2C, 1'b0, 1'b0);
    send(8'h2D, 1'b0, 1'b0);
    send(8'hEC, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    send(8'h2D, 1'b0, 1'b0);
    send_abort(8'hEC);
    send(8'h01, 1'b0, 1'b0);
    resync    = 1'b1;
    m_flag[0] = 1'b1;
    m_flag[1] = 1'b1;
    @(negedge clock);
    resync = 1'b0;
    send(8'h03, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'h87, 1'b1, 1'b0);
    send(8'h86, 1'b0, 1'b1);
    send(8'h84, 1'b0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'(1 << $urandom_range(0, 7));
        2:       m = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7)) |
                     8'(1 << $urandom_range(0, 7));
        default: m = 8'($urandom);
      endcase
      send(m_shadow[0] ^ m, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    repeat (5) @(negedge clock);
    check("dut0 leftover expected", q0.size(), 32'h0);
    check("dut1 leftover expected", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
